// File: rtl/iquant_arith.sv
// ---------------------------------------------------------------------------
// iquant_arith
//
// Inverse-quantisation arithmetic between the inverse-scan stage and the IDCT.
// Each enabled clock takes one coefficient, fetches its weighting-matrix entry
// through the external matrix read ports, scales it by the quantiser scale,
// saturates it to 12 bits and tracks mismatch-control parity over the block.
//
// Ports
//   clk, rst             clock (rising edge); synchronous active-low reset
//   clk_en               pipeline advance; low freezes every register
//   coef_valid           coefficient present on coef_* this enabled cycle
//   coef_addr[5:0]       natural-order position (row*8+col)
//   coef_level[11:0]     signed quantised level
//   coef_last            last coefficient of the block
//   intra_block          coefficient belongs to an intra block
//   quant_scale[6:0]     quantiser scale, 1..112
//   intra_dc_precision   0..3, selects the intra DC multiplier 8/4/2/1
//   mat_rd_addr[5:0]     matrix read address (combinational copy of coef_addr)
//   mat_rd_clk_en        matrix read enable (combinational copy of clk_en)
//   intra_w[7:0]         intra matrix read data
//   non_intra_w[7:0]     non-intra matrix read data
//   dq_valid             output coefficient valid
//   dq_addr[5:0]         position of the output coefficient
//   dq_coef[11:0]        signed dequantised, saturated coefficient
//   dq_last              last coefficient of the block
//   dq_mismatch          with dq_last: 1 = toggle LSB of F[7][7] downstream
//
// Flow control: there is no back-pressure. A slot carries data when its
// valid bit is 1 and moves one stage on every rising edge where clk_en is 1;
// with clk_en low every stage, the outputs and the parity register hold, so
// nothing is lost or duplicated. Slots with valid 0 are bubbles.
//
// Pipeline (one register stage per enabled edge):
//   S0 sample inputs / matrix address launched
//   S1 matrix access in progress
//   S2 weight present on intra_w / non_intra_w
//   S3 (2*level + k) * W, or the shifted intra DC value
//   S4 * quant_scale, /32 toward zero, saturate, parity -> dq_*
// ---------------------------------------------------------------------------
module iquant_arith (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        coef_valid,
  input  logic [5:0]  coef_addr,
  input  logic [11:0] coef_level,
  input  logic        coef_last,
  input  logic        intra_block,
  input  logic [6:0]  quant_scale,
  input  logic [1:0]  intra_dc_precision,
  output logic [5:0]  mat_rd_addr,
  output logic        mat_rd_clk_en,
  input  logic [7:0]  intra_w,
  input  logic [7:0]  non_intra_w,
  output logic        dq_valid,
  output logic [5:0]  dq_addr,
  output logic [11:0] dq_coef,
  output logic        dq_last,
  output logic        dq_mismatch
);

  // Per-coefficient state carried through S0..S2.
  typedef struct packed {
    logic        valid;
    logic [5:0]  addr;
    logic [11:0] level;
    logic        last;
    logic        intra;
    logic        is_dc;
    logic [6:0]  qs;
    logic [1:0]  dc_prec;
  } stage_t;

  // S3 no longer needs the level or intra flags: the product replaces them.
  typedef struct packed {
    logic        valid;
    logic [5:0]  addr;
    logic        last;
    logic        is_dc;
    logic [6:0]  qs;
    logic [21:0] prod;
  } prod_t;

  stage_t s0_d, s0_q;
  stage_t s1_q;
  stage_t s2_q;
  prod_t  s3_d, s3_q;

  logic        dq_valid_q;
  logic [5:0]  dq_addr_q;
  logic [11:0] dq_coef_q;
  logic        dq_last_q;
  logic        dq_mismatch_q;
  logic        par_q, par_d;

  // Matrix read port follows the input directly so that its two-edge
  // latency lines the weight up with S2.
  assign mat_rd_addr   = coef_addr;
  assign mat_rd_clk_en = clk_en;

  // -------------------------------------------------------------------------
  // S0 capture
  // -------------------------------------------------------------------------
  always_comb begin
    s0_d         = '0;
    s0_d.valid   = coef_valid;
    s0_d.addr    = coef_addr;
    s0_d.level   = coef_level;
    s0_d.last    = coef_last;
    s0_d.intra   = intra_block;
    s0_d.is_dc   = intra_block && (coef_addr == 6'd0);
    s0_d.qs      = quant_scale;
    s0_d.dc_prec = intra_dc_precision;
  end

  // -------------------------------------------------------------------------
  // S2 -> S3: weight multiply (or intra DC shift)
  // -------------------------------------------------------------------------
  logic [7:0]         w_sel;
  logic signed [13:0] lvl2k;
  logic signed [21:0] prod_w;
  logic signed [21:0] dc_val;

  always_comb begin
    w_sel = s2_q.intra ? intra_w : non_intra_w;

    // 2*level, then + sign(level) for non-intra; sign(0) = 0.
    lvl2k = {s2_q.level[11], s2_q.level, 1'b0};
    if (!s2_q.intra && (s2_q.level != 12'd0)) begin
      if (s2_q.level[11]) lvl2k = lvl2k - 14'sd1;
      else                lvl2k = lvl2k + 14'sd1;
    end

    // W is an unsigned weight; zero-extend before the signed multiply.
    prod_w = 22'(lvl2k) * $signed({14'd0, w_sel});

    // Intra DC bypasses W and quant_scale: level * 8/4/2/1.
    dc_val = 22'($signed(s2_q.level)) <<< (2'd3 - s2_q.dc_prec);

    s3_d       = '0;
    s3_d.valid = s2_q.valid;
    s3_d.addr  = s2_q.addr;
    s3_d.last  = s2_q.last;
    s3_d.is_dc = s2_q.is_dc;
    s3_d.qs    = s2_q.qs;
    s3_d.prod  = s2_q.is_dc ? dc_val : prod_w;
  end

  // -------------------------------------------------------------------------
  // S3 -> S4: scale, divide toward zero, saturate, parity
  // -------------------------------------------------------------------------
  logic signed [28:0] prod_q;
  logic signed [28:0] biased;
  logic signed [28:0] f_full;
  logic [11:0]        f_sat;

  always_comb begin
    prod_q = 29'($signed(s3_q.prod)) * $signed({22'd0, s3_q.qs});
    // Arithmetic shift floors; biasing negatives by 31 turns that into
    // truncation toward zero.
    biased = prod_q + (prod_q[28] ? 29'sd31 : 29'sd0);
    f_full = s3_q.is_dc ? 29'($signed(s3_q.prod)) : (biased >>> 5);

    if (f_full > 29'sd2047)        f_sat = 12'h7ff;
    else if (f_full < -29'sd2048)  f_sat = 12'h800;
    else                           f_sat = f_full[11:0];
  end

  // Parity accumulates the LSB of every real output and restarts after the
  // last coefficient of a block; bubbles leave it alone.
  always_comb begin
    par_d = par_q;
    if (s3_q.valid) begin
      if (s3_q.last) par_d = 1'b0;
      else           par_d = par_q ^ f_sat[0];
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      s0_q          <= '0;
      s1_q          <= '0;
      s2_q          <= '0;
      s3_q          <= '0;
      dq_valid_q    <= 1'b0;
      dq_addr_q     <= 6'd0;
      dq_coef_q     <= 12'd0;
      dq_last_q     <= 1'b0;
      dq_mismatch_q <= 1'b0;
      par_q         <= 1'b0;
    end else if (clk_en) begin
      s0_q          <= s0_d;
      s1_q          <= s0_q;
      s2_q          <= s1_q;
      s3_q          <= s3_d;
      dq_valid_q    <= s3_q.valid;
      dq_addr_q     <= s3_q.addr;
      dq_coef_q     <= f_sat;
      dq_last_q     <= s3_q.valid & s3_q.last;
      // Set when the block's LSB sum is even.
      dq_mismatch_q <= s3_q.valid & s3_q.last & ~(par_q ^ f_sat[0]);
      par_q         <= par_d;
    end
  end

  assign dq_valid    = dq_valid_q;
  assign dq_addr     = dq_addr_q;
  assign dq_coef     = dq_coef_q;
  assign dq_last     = dq_last_q;
  assign dq_mismatch = dq_mismatch_q;

endmodule

// File: tb/tb_iquant_arith.sv
// ---------------------------------------------------------------------------
// tb_iquant_arith
//
// Directed bench for iquant_arith. A behavioural matrix model supplies the
// weights two enabled edges after the address. The driver pushes hand-computed
// expected outputs, tagged with the enabled edge they must appear on, into a
// queue; the monitor pops them as dq_valid outputs arrive.
// ---------------------------------------------------------------------------
module tb_iquant_arith;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        coef_valid;
  logic [5:0]  coef_addr;
  logic [11:0] coef_level;
  logic        coef_last;
  logic        intra_block;
  logic [6:0]  quant_scale;
  logic [1:0]  intra_dc_precision;
  logic [5:0]  mat_rd_addr;
  logic        mat_rd_clk_en;
  logic [7:0]  intra_w = 8'd0;
  logic [7:0]  non_intra_w = 8'd0;
  logic        dq_valid;
  logic [5:0]  dq_addr;
  logic [11:0] dq_coef;
  logic        dq_last;
  logic        dq_mismatch;

  always #5 clk = ~clk;

  iquant_arith dut (
    .clk                (clk),
    .rst                (rst),
    .clk_en             (clk_en),
    .coef_valid         (coef_valid),
    .coef_addr          (coef_addr),
    .coef_level         (coef_level),
    .coef_last          (coef_last),
    .intra_block        (intra_block),
    .quant_scale        (quant_scale),
    .intra_dc_precision (intra_dc_precision),
    .mat_rd_addr        (mat_rd_addr),
    .mat_rd_clk_en      (mat_rd_clk_en),
    .intra_w            (intra_w),
    .non_intra_w        (non_intra_w),
    .dq_valid           (dq_valid),
    .dq_addr            (dq_addr),
    .dq_coef            (dq_coef),
    .dq_last            (dq_last),
    .dq_mismatch        (dq_mismatch)
  );

  // -------------------------------------------------------------------------
  // Matrix model: intra row r holds 16+2r, except [0]=8 and [63]=83 as in the
  // default intra matrix; non-intra is flat 16.
  // -------------------------------------------------------------------------
  logic [7:0] rom_i [64];
  logic [7:0] rom_n [64];
  logic [5:0] ra1 = 6'd0;
  logic [5:0] ra2 = 6'd0;

  initial begin
    for (int i = 0; i < 64; i++) begin
      rom_i[i] = 8'(16 + 2 * (i / 8));
      rom_n[i] = 8'd16;
    end
    rom_i[0]  = 8'd8;
    rom_i[63] = 8'd83;
  end

  always @(posedge clk) begin
    if (mat_rd_clk_en) begin
      ra1         <= mat_rd_addr;
      ra2         <= ra1;
      intra_w     <= rom_i[ra2];
      non_intra_w <= rom_n[ra2];
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  localparam int W = 44;  // {edge[23:0], addr[5:0], coef[11:0], last, mismatch}
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;
  int edge_n = 0;         // enabled, non-reset edges seen so far
  bit stall_mode = 1'b0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  function automatic logic pick_en();
    if (stall_mode) return 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  // Present one coefficient and hold it until an enabled edge takes it.
  task automatic send(input logic [5:0] a, input int lvl, input logic lst,
                      input logic intra, input int qs, input int prec,
                      input int ef, input logic em);
    int tries;
    tries = 0;
    @(negedge clk);
    coef_valid         = 1'b1;
    coef_addr          = a;
    coef_level         = 12'(lvl);
    coef_last          = lst;
    intra_block        = intra;
    quant_scale        = 7'(qs);
    intra_dc_precision = 2'(prec);
    clk_en             = pick_en();
    while (!clk_en) begin
      @(negedge clk);
      tries++;
      clk_en = (tries > 50) ? 1'b1 : pick_en();
    end
    // Sampled on enabled edge edge_n+1, visible after edge_n+5.
    exp_q.push_back({24'(edge_n + 5), a, 12'(ef), lst, em});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      coef_valid = 1'b0;
      clk_en     = pick_en();
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      idle(1);
      k++;
    end
    idle(2);
    check("drain_empty", exp_q.size(), 0);
  endtask

  // -------------------------------------------------------------------------
  // Monitor: checks each output against the queue head, including the edge
  // it should land on, so late, early, dropped or duplicated outputs show up.
  // -------------------------------------------------------------------------
  logic         mon_en;
  logic         mon_rst;
  logic [W-1:0] mon_e;

  always @(posedge clk) begin
    mon_en  = clk_en;
    mon_rst = rst;
    if (mon_en && mon_rst) edge_n++;
    #1;
    if (!mon_rst) begin
      check("rst_dq_valid", dq_valid, 0);
    end else if (mon_en) begin
      if (dq_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("latency_edge", edge_n, mon_e[43:20]);
          check("dq_addr", dq_addr, mon_e[19:14]);
          check("dq_coef", $signed(dq_coef), $signed(mon_e[13:2]));
          check("dq_last", dq_last, mon_e[1]);
          check("dq_mismatch", dq_mismatch, mon_e[0]);
        end
      end else if (exp_q.size() != 0 && int'(exp_q[0][43:20]) <= edge_n) begin
        check("missing_out", 0, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    rst                = 1'b0;
    clk_en             = 1'b1;
    coef_valid         = 1'b0;
    coef_addr          = 6'd0;
    coef_level         = 12'd0;
    coef_last          = 1'b0;
    intra_block        = 1'b0;
    quant_scale        = 7'd1;
    intra_dc_precision = 2'd0;

    repeat (3) @(negedge clk);
    check("rst_dq_addr", dq_addr, 0);
    check("rst_dq_coef", dq_coef, 0);
    check("rst_dq_last", dq_last, 0);
    check("rst_dq_mismatch", dq_mismatch, 0);

    // Matrix port pass-through.
    coef_addr = 6'd37;
    clk_en    = 1'b0;
    #1;
    check("mat_rd_addr", mat_rd_addr, 37);
    check("mat_rd_clk_en_lo", mat_rd_clk_en, 0);
    clk_en = 1'b1;
    #1;
    check("mat_rd_clk_en_hi", mat_rd_clk_en, 1);
    coef_addr = 6'd0;

    @(negedge clk);
    rst = 1'b1;

    // Directed vectors, back to back. Single-coefficient blocks give
    // mismatch = 1 exactly when the value is even.
    //    addr  level  last intra qs  prec  expect mism
    send(6'd0,   100, 1'b1, 1'b1,  5,  0,    800, 1'b1); // intra DC x8
    send(6'd0,   100, 1'b1, 1'b1,  5,  3,    100, 1'b1); // intra DC x1
    send(6'd0,    -7, 1'b1, 1'b1,  9,  2,    -14, 1'b1); // intra DC x2
    send(6'd1,     3, 1'b1, 1'b1,  8,  0,     24, 1'b1); // 6*16*8/32
    send(6'd1,    -3, 1'b1, 1'b1,  8,  0,    -24, 1'b1);
    send(6'd10,    4, 1'b1, 1'b1, 16,  0,     72, 1'b1); // 8*18*16/32
    send(6'd0,    -5, 1'b1, 1'b0,  9,  0,    -49, 1'b0); // -1584/32
    send(6'd0,     0, 1'b1, 1'b0,  9,  0,      0, 1'b1);
    send(6'd63, 2047, 1'b1, 1'b1, 112, 0,   2047, 1'b0); // saturate high
    send(6'd63,-2048, 1'b1, 1'b1, 112, 0,  -2048, 1'b1); // saturate low
    send(6'd0,     1, 1'b1, 1'b0,  2,  0,      3, 1'b0); // 96/32
    send(6'd0,     1, 1'b1, 1'b0,  4,  0,      6, 1'b1); // 192/32
    send(6'd0,     1, 1'b0, 1'b0,  2,  0,      3, 1'b0); // 3 + 3 block
    send(6'd1,     1, 1'b1, 1'b0,  2,  0,      3, 1'b1);
    drain();

    // Stream of 8 under random clk_en. LSBs 1,1,1,0,0,0,1,0 -> even sum.
    stall_mode = 1'b1;
    send(6'd0,     1, 1'b0, 1'b0,  2,  0,      3, 1'b0); // 3*2/2
    send(6'd1,     2, 1'b0, 1'b0,  3,  0,      7, 1'b0); // 15/2
    send(6'd2,    -1, 1'b0, 1'b0,  5,  0,     -7, 1'b0); // -15/2
    send(6'd3,     4, 1'b0, 1'b0,  1,  0,      4, 1'b0); // 9/2
    send(6'd1,     5, 1'b0, 1'b1,  4,  0,     20, 1'b0); // 10*16*4/32
    send(6'd0,    -7, 1'b0, 1'b1,  3,  1,    -28, 1'b0); // DC x4
    send(6'd9,    10, 1'b0, 1'b0, 10,  0,    105, 1'b0); // 210/2
    send(6'd63,   -3, 1'b1, 1'b0,  7,  0,    -24, 1'b1); // -784/32
    drain();
    stall_mode = 1'b0;

    // Mid-block reset: first coefficient (odd, p -> 1) completes, second is
    // in flight when rst drops and must never appear.
    send(6'd0,     1, 1'b0, 1'b0,  2,  0,      3, 1'b0);
    idle(6);
    send(6'd1,     2, 1'b0, 1'b0,  3,  0,      7, 1'b0);
    idle(1);
    @(negedge clk);
    rst        = 1'b0;
    clk_en     = 1'b1;
    coef_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    check("post_rst_dq_valid", dq_valid, 0);
    // Parity restarted at 0: a lone 3 must give mismatch 0.
    send(6'd0,     1, 1'b1, 1'b0,  2,  0,      3, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
